// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter that raises an interrupt on expiry.
// One-shot mode holds a level interrupt until acknowledged; auto-reload pulses once per period.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        writeEnable,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        irq
);

  localparam int unsigned DataW = 32;
  localparam int unsigned CtrlW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CtrlW-1:0]   ctrl_q, ctrl_d;
  logic [DataW-1:0]   preset_q, preset_d;
  logic [DataW-1:0]   count_q, count_d;
  logic               irq_flag_q, irq_flag_d;

  logic enable;
  logic auto_reload;
  logic wr_ctrl;
  logic wr_preset;
  logic terminal;

  assign enable      = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign wr_ctrl     = writeEnable && (addr == 2'd0);
  assign wr_preset   = writeEnable && (addr == 2'd1);
  assign terminal    = (state_q == S_CNT) && enable && (count_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_LOAD;
      S_LOAD:  state_d = S_CNT;
      S_CNT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (count_q == '0) begin
          state_d = S_INT;
        end
      end
      S_INT:   state_d = auto_reload ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Register-file and counter updates; bus writes override the hardware enable clear,
  // and a new expiry overrides any acknowledge on the same edge.
  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    if (state_q == S_LOAD) begin
      count_d = preset_q;
    end else if ((state_q == S_CNT) && enable && (count_q != '0)) begin
      count_d = count_q - DataW'(1);
    end

    if (terminal && !auto_reload) begin
      ctrl_d[0] = 1'b0;
    end
    if (wr_ctrl) begin
      ctrl_d = writeData[CtrlW-1:0];
    end
    if (wr_preset) begin
      preset_d = writeData;
    end

    if (wr_ctrl || wr_preset) begin
      irq_flag_d = 1'b0;
    end
    if ((state_q == S_INT) && auto_reload) begin
      irq_flag_d = 1'b0;
    end
    if (terminal) begin
      irq_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    readData = '0;
    case (addr)
      2'd0:    readData = {{(DataW-CtrlW){1'b0}}, ctrl_q};
      2'd1:    readData = preset_q;
      2'd2:    readData = count_q;
      default: readData = '0;
    endcase
  end

  assign irq = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: per-cycle reference model plus directed literal checks.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        writeEnable;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        irq;

  timer_counter dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .writeEnable (writeEnable),
    .writeData   (writeData),
    .readData    (readData),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_CNT  = 2;
  localparam int PH_INT  = 3;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        flag;
    int          ph;
  } mstate_t;

  mstate_t m;
  int      cyc = 0;
  int      passed = 0;
  int      total = 0;
  logic    chk_on = 1'b0;
  int      highs;
  int      t, t2, t3;
  logic [31:0] exp_cnt [6] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
  logic        exp_irq [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  // Reference behaviour of one clock edge
  function automatic mstate_t model_next(input mstate_t s, input logic rst, input logic we,
                                         input logic [1:0] a, input logic [31:0] d);
    mstate_t n;
    logic    expire;
    logic    reload_mode;
    n = s;
    expire = 1'b0;
    reload_mode = (s.ctrl[2:1] == 2'd1);
    if (rst) begin
      n.ctrl = '0; n.preset = '0; n.count = '0; n.flag = 1'b0; n.ph = PH_IDLE;
      return n;
    end
    case (s.ph)
      PH_IDLE: if (s.ctrl[0]) n.ph = PH_LOAD;
      PH_LOAD: begin n.count = s.preset; n.ph = PH_CNT; end
      PH_CNT: begin
        if (!s.ctrl[0]) n.ph = PH_IDLE;
        else if (s.count > 0) n.count = s.count - 32'd1;
        else begin n.ph = PH_INT; expire = 1'b1; end
      end
      PH_INT:  n.ph = reload_mode ? PH_LOAD : PH_IDLE;
      default: n.ph = PH_IDLE;
    endcase
    if (expire && !reload_mode) n.ctrl[0] = 1'b0;
    if (we && a == 2'd1) n.preset = d;
    if (we && a == 2'd0) n.ctrl = d[3:0];
    if (we && a <= 2'd1) n.flag = 1'b0;
    if (s.ph == PH_INT && reload_mode) n.flag = 1'b0;
    if (expire) n.flag = 1'b1;
    return n;
  endfunction

  function automatic logic [31:0] model_read(input mstate_t s, input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, s.ctrl};
      2'd1:    return s.preset;
      2'd2:    return s.count;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    m   <= model_next(m, reset, writeEnable, addr, writeData);
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  // Continuous comparison against the model, sampled 2 time units after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (chk_on) begin
        chk("model_irq", {31'd0, irq}, {31'd0, m.flag & m.ctrl[3]});
        chk("model_readData", readData, model_read(m, addr));
      end
    end
  end

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, output int edge_idx);
    @(negedge clk);
    addr = a; writeData = d; writeEnable = 1'b1;
    edge_idx = cyc + 1;
    @(negedge clk);
    writeEnable = 1'b0;
  endtask

  task automatic sel(input logic [1:0] a);
    @(negedge clk);
    addr = a;
  endtask

  task automatic wait_edge(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; writeEnable = 1'b0; addr = 2'd0; writeData = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_on = 1'b1;

    // reset values
    for (int a = 0; a < 4; a++) begin
      sel(2'(a));
      @(posedge clk); #2;
      chk("reset_read", readData, 32'd0);
    end
    chk("reset_irq", {31'd0, irq}, 32'd0);

    // one-shot: irq rises at t+8 and holds; enable self-clears
    bus_wr(2'd1, 32'd5, t);
    bus_wr(2'd0, 32'h9, t);
    wait_edge(t + 7);
    chk("oneshot_early", {31'd0, irq}, 32'd0);
    wait_edge(t + 8);
    chk("oneshot_rise", {31'd0, irq}, 32'd1);
    chk("oneshot_ctrl", readData, 32'h8);
    wait_edge(t + 14);
    chk("oneshot_hold", {31'd0, irq}, 32'd1);
    sel(2'd2);
    @(posedge clk); #2;
    chk("oneshot_count", readData, 32'd0);
    bus_wr(2'd0, 32'h8, t);
    chk("ack_ctrl", {31'd0, irq}, 32'd0);

    // acknowledge through a PRESET write
    bus_wr(2'd0, 32'h9, t);
    wait_edge(t + 8);
    chk("oneshot2_rise", {31'd0, irq}, 32'd1);
    bus_wr(2'd1, 32'd5, t2);
    chk("ack_preset", {31'd0, irq}, 32'd0);

    // auto-reload: period 6 pulses, count 3,2,1,0,0,0
    bus_wr(2'd1, 32'd3, t);
    bus_wr(2'd0, 32'hB, t);
    sel(2'd2);
    for (int i = 0; i < 6; i++) begin
      wait_edge(t + 2 + i);
      chk("reload_count", readData, exp_cnt[i]);
      chk("reload_irq", {31'd0, irq}, {31'd0, exp_irq[i]});
    end
    for (int k = 1; k <= 4; k++) begin
      wait_edge(t + 6 + 6 * k);
      chk("reload_pulse", {31'd0, irq}, 32'd1);
      wait_edge(t + 7 + 6 * k);
      chk("reload_pulse_end", {31'd0, irq}, 32'd0);
    end
    bus_wr(2'd0, 32'h0, t);
    repeat (8) @(negedge clk);

    // masking: flag sets under IM=0 and is cleared by CTRL or PRESET writes
    bus_wr(2'd1, 32'd2, t);
    bus_wr(2'd0, 32'h1, t);
    wait_edge(t + 7);
    chk("mask_irq", {31'd0, irq}, 32'd0);
    bus_wr(2'd0, 32'h8, t2);
    wait_edge(t2 + 1);
    chk("mask_ack_ctrl", {31'd0, irq}, 32'd0);
    bus_wr(2'd0, 32'h1, t);
    wait_edge(t + 7);
    chk("mask_irq2", {31'd0, irq}, 32'd0);
    bus_wr(2'd1, 32'd2, t2);
    bus_wr(2'd0, 32'h8, t3);
    wait_edge(t3 + 1);
    chk("mask_ack_preset", {31'd0, irq}, 32'd0);

    // collision: CTRL write on the terminal edge keeps Enable and the flag
    bus_wr(2'd0, 32'h9, t);
    repeat (3) @(negedge clk);
    bus_wr(2'd0, 32'h9, t2);
    wait_edge(t + 5);
    chk("coll_edge", t2, t + 5);
    chk("coll_irq", {31'd0, irq}, 32'd1);
    chk("coll_enable", readData, 32'h9);
    sel(2'd2);
    wait_edge(t + 8);
    chk("coll_reload", readData, 32'd2);
    bus_wr(2'd0, 32'h0, t);
    repeat (6) @(negedge clk);

    // PRESET write mid-count does not disturb COUNT, then reset aborts
    bus_wr(2'd1, 32'd10, t);
    bus_wr(2'd0, 32'hB, t);
    wait_edge(t + 4);
    bus_wr(2'd1, 32'd1, t2);
    sel(2'd2);
    wait_edge(t + 9);
    chk("midcount_preset", readData, 32'd3);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("abort_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      sel(2'(a));
      @(posedge clk); #2;
      chk("abort_read", readData, 32'd0);
    end
    highs = 0;
    repeat (20) begin
      @(posedge clk); #2;
      if (irq) highs++;
    end
    chk("abort_quiet", 32'(highs), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
